// File: rtl/mem_access.sv
// MEM stage of the MIPS pipeline: data-memory request/ready handshake, stall, MEM/WB register, branch resolve.
// Optional bus timeout (sticky bus_err) is compiled in with `define MEM_TIMEOUT_EN.
module mem_access #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   res,
    input  logic [31:0]   write_data_ex,
    input  logic [4:0]    write_register_ex,
    input  logic          zero,
    input  logic [2:0]    m_MEM,
    input  logic [1:0]    wb_MEM,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ready,
    input  logic [31:0]   dmem_rdata,
    output logic          mem_stall,
    output logic          pc_src,
    output logic          align_err,
    output logic          bus_err,
    output logic [4:0]    rd_WB,
    output logic [1:0]    wb_WB,
    output logic [31:0]   read_data_wb,
    output logic [31:0]   res_wb,
    output logic [31:0]   write_data_reg
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // What the MEM/WB register loads this cycle.
    typedef enum logic [1:0] {
        WB_BUBBLE,
        WB_ALU,
        WB_MEM,
        WB_LAT
    } wb_sel_t;

    state_t  state, next_state;
    wb_sel_t wb_sel;

    logic          acc;
    logic          misaligned;
    logic          latch_req;
    logic          timeout_hit;

    logic [AW-1:0] lat_addr;
    logic          lat_we;
    logic [31:0]   lat_wdata;
    logic [4:0]    lat_rd;
    logic [1:0]    lat_wb;
    logic [31:0]   lat_res;

    assign acc        = m_MEM[1] | m_MEM[0];
    assign misaligned = acc & (res[1:0] != 2'b00);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        wb_sel     = WB_BUBBLE;
        latch_req  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = m_MEM[0];
        dmem_addr  = {res[AW-1:2], 2'b00};
        dmem_wdata = write_data_ex;
        mem_stall  = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc && !misaligned) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        wb_sel = WB_MEM;
                    end else begin
                        mem_stall  = 1'b1;
                        latch_req  = 1'b1;
                        next_state = S_WAIT;
                    end
                end else if (!acc) begin
                    wb_sel = WB_ALU;
                end
            end
            S_WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = lat_we;
                dmem_addr  = lat_addr;
                dmem_wdata = lat_wdata;
                if (dmem_ready) begin
                    wb_sel     = WB_LAT;
                    next_state = S_IDLE;
                end else begin
                    // Stall holds through the abort cycle and drops once back in IDLE.
                    mem_stall = 1'b1;
                    if (timeout_hit) next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign pc_src         = m_MEM[2] & zero & (state == S_IDLE);
    assign write_data_reg = wb_WB[0] ? read_data_wb : res_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // NOTE: the latched request is only read in S_WAIT, which is always entered through a load of
    // these registers, so they carry no reset.
    always_ff @(posedge clk) begin
        if (latch_req) begin
            lat_addr  <= {res[AW-1:2], 2'b00};
            lat_we    <= m_MEM[0];
            lat_wdata <= write_data_ex;
            lat_rd    <= write_register_ex;
            lat_wb    <= wb_MEM;
            lat_res   <= res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_WB        <= '0;
            wb_WB        <= '0;
            read_data_wb <= '0;
            res_wb       <= '0;
            align_err    <= 1'b0;
        end else begin
            align_err <= (state == S_IDLE) & misaligned;
            case (wb_sel)
                WB_ALU: begin
                    rd_WB        <= write_register_ex;
                    wb_WB        <= wb_MEM;
                    res_wb       <= res;
                    read_data_wb <= '0;
                end
                WB_MEM: begin
                    rd_WB        <= write_register_ex;
                    wb_WB        <= wb_MEM;
                    res_wb       <= res;
                    read_data_wb <= m_MEM[0] ? 32'h0 : dmem_rdata;
                end
                WB_LAT: begin
                    rd_WB        <= lat_rd;
                    wb_WB        <= lat_wb;
                    res_wb       <= lat_res;
                    read_data_wb <= lat_we ? 32'h0 : dmem_rdata;
                end
                default: begin
                    // Bubble: no register write for a stalled, aborted or misaligned slot.
                    rd_WB <= '0;
                    wb_WB <= '0;
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] wait_cnt;

    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (latch_req)                      wait_cnt <= '0;
            else if (state == S_WAIT && !dmem_ready) wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit && !dmem_ready)     bus_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT=4); timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] res, write_data_ex, dmem_rdata, dmem_wdata;
    logic [31:0] read_data_wb, res_wb, write_data_reg, dmem_addr;
    logic [4:0]  write_register_ex, rd_WB;
    logic        zero, dmem_req, dmem_we, dmem_ready, mem_stall, pc_src, align_err, bus_err;
    logic [2:0]  m_MEM;
    logic [1:0]  wb_MEM, wb_WB;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_access #(.AW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .res(res), .write_data_ex(write_data_ex),
        .write_register_ex(write_register_ex), .zero(zero), .m_MEM(m_MEM), .wb_MEM(wb_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .pc_src(pc_src),
        .align_err(align_err), .bus_err(bus_err), .rd_WB(rd_WB), .wb_WB(wb_WB),
        .read_data_wb(read_data_wb), .res_wb(res_wb), .write_data_reg(write_data_reg)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] r,
                         input logic [4:0] rd, input logic [31:0] wd, input logic rdy,
                         input logic [31:0] rdata);
        m_MEM = m; wb_MEM = wb; res = r; write_register_ex = rd;
        write_data_ex = wd; dmem_ready = rdy; dmem_rdata = rdata; zero = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        tick();
        total++; if (rd_WB !== 5'd0) $display("FAIL reset_rd got=%0d exp=0", rd_WB); else passed++;
        total++; if (wb_WB !== 2'b00) $display("FAIL reset_wb got=%b exp=00", wb_WB); else passed++;
        total++; if (read_data_wb !== 32'h0 || res_wb !== 32'h0)
            $display("FAIL reset_data got=%h/%h exp=0/0", read_data_wb, res_wb); else passed++;
        total++; if ({dmem_req, mem_stall, align_err, bus_err} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000", {dmem_req, mem_stall, align_err, bus_err}); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait_load();
        drive(3'b010, 2'b11, 32'h40, 5'd8, 32'h0, 1'b1, 32'hDEADBEEF);
        total++; if ({dmem_req, dmem_we, mem_stall} !== 3'b100 || dmem_addr !== 32'h40)
            $display("FAIL zw_req got=%b addr=%h exp=100 addr=40", {dmem_req, dmem_we, mem_stall}, dmem_addr); else passed++;
        tick();
        drive(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        total++; if (rd_WB !== 5'd8 || wb_WB !== 2'b11)
            $display("FAIL zw_cap got=%0d/%b exp=8/11", rd_WB, wb_WB); else passed++;
        total++; if (write_data_reg !== 32'hDEADBEEF)
            $display("FAIL zw_wdr got=%h exp=deadbeef", write_data_reg); else passed++;
    endtask

    task automatic test_wait_store();
        drive(3'b001, 2'b00, 32'h100, 5'd3, 32'h1234, 1'b0, 32'h0);
        total++; if ({dmem_req, dmem_we, mem_stall} !== 3'b111 || dmem_addr !== 32'h100 || dmem_wdata !== 32'h1234)
            $display("FAIL st_c1 got=%b %h %h exp=111 100 1234", {dmem_req, dmem_we, mem_stall}, dmem_addr, dmem_wdata); else passed++;
        tick();
        // EX/MEM inputs change while waiting; request must stay latched and pc_src forced low.
        drive(3'b100, 2'b10, 32'hFFF0, 5'd9, 32'h0, 1'b0, 32'h0);
        zero = 1'b1; #1;
        for (int c = 2; c <= 3; c++) begin
            total++; if ({dmem_req, dmem_we, mem_stall} !== 3'b111 || dmem_addr !== 32'h100 || dmem_wdata !== 32'h1234)
                $display("FAIL st_hold c%0d got=%b %h %h exp=111 100 1234", c, {dmem_req, dmem_we, mem_stall}, dmem_addr, dmem_wdata); else passed++;
            total++; if (wb_WB !== 2'b00 || rd_WB !== 5'd0)
                $display("FAIL st_bubble c%0d got=%b/%0d exp=00/0", c, wb_WB, rd_WB); else passed++;
            total++; if (pc_src !== 1'b0) $display("FAIL st_pcsrc c%0d got=%b exp=0", c, pc_src); else passed++;
            tick();
        end
        dmem_ready = 1'b1; #1;
        total++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1)
            $display("FAIL st_done got=stall%b req%b exp=stall0 req1", mem_stall, dmem_req); else passed++;
        tick();
        drive(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        total++; if (rd_WB !== 5'd3 || wb_WB !== 2'b00 || res_wb !== 32'h100 || read_data_wb !== 32'h0)
            $display("FAIL st_cap got=%0d/%b/%h/%h exp=3/00/100/0", rd_WB, wb_WB, res_wb, read_data_wb); else passed++;
    endtask

    task automatic test_alu_bypass();
        drive(3'b000, 2'b10, 32'h55, 5'd9, 32'h0, 1'b1, 32'hAAAA5555);
        total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL alu_req got=%b/%b exp=0/0", dmem_req, mem_stall); else passed++;
        tick();
        drive(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        total++; if (res_wb !== 32'h55 || write_data_reg !== 32'h55 || read_data_wb !== 32'h0)
            $display("FAIL alu_cap got=%h/%h/%h exp=55/55/0", res_wb, write_data_reg, read_data_wb); else passed++;
        total++; if (wb_WB !== 2'b10 || rd_WB !== 5'd9)
            $display("FAIL alu_ctl got=%b/%0d exp=10/9", wb_WB, rd_WB); else passed++;
    endtask

    task automatic test_branch();
        drive(3'b100, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        zero = 1'b1; #1;
        total++; if (pc_src !== 1'b1) $display("FAIL br_taken got=%b exp=1", pc_src); else passed++;
        zero = 1'b0; #1;
        total++; if (pc_src !== 1'b0) $display("FAIL br_not got=%b exp=0", pc_src); else passed++;
        tick();
    endtask

    task automatic test_misaligned();
        drive(3'b010, 2'b11, 32'h42, 5'd7, 32'h0, 1'b1, 32'h12345678);
        total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL mis_req got=%b/%b exp=0/0", dmem_req, mem_stall); else passed++;
        tick();
        drive(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        total++; if (align_err !== 1'b1 || wb_WB !== 2'b00 || rd_WB !== 5'd0)
            $display("FAIL mis_cap got=%b/%b/%0d exp=1/00/0", align_err, wb_WB, rd_WB); else passed++;
        tick();
        total++; if (align_err !== 1'b0) $display("FAIL mis_pulse got=%b exp=0", align_err); else passed++;
    endtask

    task automatic test_back_to_back();
        drive(3'b010, 2'b11, 32'h80, 5'd4, 32'h0, 1'b1, 32'h11111111);
        tick();
        drive(3'b010, 2'b11, 32'h84, 5'd5, 32'h0, 1'b0, 32'h0);
        total++; if (rd_WB !== 5'd4 || write_data_reg !== 32'h11111111)
            $display("FAIL b2b_first got=%0d/%h exp=4/11111111", rd_WB, write_data_reg); else passed++;
        total++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1 || dmem_addr !== 32'h84)
            $display("FAIL b2b_issue got=%b/%b/%h exp=1/1/84", dmem_req, mem_stall, dmem_addr); else passed++;
        tick();
        total++; if (wb_WB !== 2'b00) $display("FAIL b2b_bubble got=%b exp=00", wb_WB); else passed++;
        dmem_ready = 1'b1; dmem_rdata = 32'h22222222; #1;
        tick();
        drive(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        total++; if (rd_WB !== 5'd5 || wb_WB !== 2'b11 || write_data_reg !== 32'h22222222)
            $display("FAIL b2b_second got=%0d/%b/%h exp=5/11/22222222", rd_WB, wb_WB, write_data_reg); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        drive(3'b010, 2'b11, 32'h10, 5'd2, 32'h0, 1'b0, 32'h0);
        tick();
        total++; if (mem_stall !== 1'b1) $display("FAIL rmw_wait got=%b exp=1", mem_stall); else passed++;
        drive(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b0; #1;
        total++; if ({dmem_req, mem_stall} !== 2'b00 || wb_WB !== 2'b00)
            $display("FAIL rmw_drop got=%b/%b exp=00/00", {dmem_req, mem_stall}, wb_WB); else passed++;
        tick();
        rst_n = 1'b1;
        dmem_ready = 1'b1; #1;
        tick();
        total++; if (dmem_req !== 1'b0 || wb_WB !== 2'b00 || rd_WB !== 5'd0)
            $display("FAIL rmw_after got=%b/%b/%0d exp=0/00/0", dmem_req, wb_WB, rd_WB); else passed++;
        dmem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        drive(3'b010, 2'b11, 32'h200, 5'd6, 32'h0, 1'b0, 32'h0);
        tick();
        drive(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
`ifdef MEM_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            total++; if (mem_stall !== 1'b1 || bus_err !== 1'b0)
                $display("FAIL to_wait c%0d got=%b/%b exp=1/0", c, mem_stall, bus_err); else passed++;
            tick();
        end
        total++; if (bus_err !== 1'b1 || mem_stall !== 1'b0 || wb_WB !== 2'b00)
            $display("FAIL to_abort got=%b/%b/%b exp=1/0/00", bus_err, mem_stall, wb_WB); else passed++;
        tick(); tick();
        total++; if (bus_err !== 1'b1 || wb_WB !== 2'b00)
            $display("FAIL to_sticky got=%b/%b exp=1/00", bus_err, wb_WB); else passed++;
        rst_n = 1'b0; #1;
        total++; if (bus_err !== 1'b0) $display("FAIL to_clear got=%b exp=0", bus_err); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
`else
        for (int c = 1; c <= 6; c++) tick();
        total++; if (mem_stall !== 1'b1 || bus_err !== 1'b0)
            $display("FAIL nto_wait got=%b/%b exp=1/0", mem_stall, bus_err); else passed++;
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D; #1;
        tick();
        dmem_ready = 1'b0;
        total++; if (rd_WB !== 5'd6 || write_data_reg !== 32'hCAFEF00D)
            $display("FAIL nto_cap got=%0d/%h exp=6/cafef00d", rd_WB, write_data_reg); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_alu_bypass();
        test_branch();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the MIPS pipeline; consumes the EX/MEM pipeline register driven by the execute stage: result, store data, destination register, M and WB control bits.
- Drives a word-wide data-memory request/ready bus.
- Stalls the upstream pipeline while an access is outstanding.
- Produces the MEM/WB pipeline register and the write-back value that feeds the forwarding path.
- Resolves branches (pc_src).

Parameters:
- AW, 32, data-memory byte address width; low AW bits of res are used.
- TIMEOUT, 16, max cycles waiting for dmem_ready (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- res  in  32  EX/MEM ALU result; load/store byte address
- write_data_ex  in  32  EX/MEM store data
- write_register_ex  in  5  EX/MEM destination register
- zero  in  1  EX/MEM ALU zero flag
- m_MEM  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
- wb_MEM  in  2  [1]=reg_write, [0]=mem_to_reg
- dmem_req  out  1  access request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  AW  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_ready  in  1  access complete this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1  branch taken = m_MEM[2] & zero
- align_err  out  1  one-cycle pulse on misaligned access
- bus_err  out  1  sticky timeout flag
- rd_WB  out  5  MEM/WB destination register
- wb_WB  out  2  MEM/WB control
- read_data_wb  out  32  MEM/WB load data
- res_wb  out  32  MEM/WB ALU result
- write_data_reg  out  32  wb_WB[0] ? read_data_wb : res_wb (combinational)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - rd_WB=0, wb_WB=0, read_data_wb=0, res_wb=0, align_err=0, bus_err=0, timeout counter=0.
  - Combinational outputs therefore read dmem_req=0, mem_stall=0.
- Access: acc = m_MEM[1] | m_MEM[0]. If both bits are set, treat as store.
- Misaligned: acc & res[1:0]!=0.
  - No request issued; align_err=1 for one cycle.
  - MEM/WB gets a bubble: wb_WB<=0, rd_WB<=0.
  - No stall.
- FSM states: IDLE, WAIT.
- IDLE:
  - If acc and aligned: dmem_req=1 combinationally, with dmem_addr=res with [1:0] forced 0, dmem_we=m_MEM[0], dmem_wdata=write_data_ex.
  - If dmem_ready=1 in the same cycle: zero-wait completion, no stall, MEM/WB captures normally.
  - If dmem_ready=0: latch addr/we/wdata/rd/wb/res, go to WAIT, mem_stall=1 this cycle, MEM/WB gets a bubble.
  - Non-access instruction: MEM/WB captures normally, read_data_wb<=0.
- WAIT:
  - dmem_req=1 with the latched request; mem_stall=1.
  - MEM/WB gets a bubble each cycle until dmem_ready.
  - On dmem_ready=1: mem_stall=0 in that cycle. MEM/WB captures the latched rd/wb/res and read_data_wb<=dmem_rdata (loads; 0 for stores). Next state IDLE.
- Normal capture: rd_WB<=write_register_ex, wb_WB<=wb_MEM, res_wb<=res.
- Write-back exactly once per instruction: bubbles guarantee no duplicate register write during stall.
- pc_src is combinational from the EX/MEM inputs and is forced 0 while state=WAIT.
- Reset mid-WAIT: return to IDLE immediately; the request is dropped; no MEM/WB capture.
- dmem_ready while dmem_req=0 is ignored.
- Back-to-back accesses: the next access may issue in the cycle after completion.

Optional Feature:
- Macro: MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT-1 with no dmem_ready: abort, bus_err<=1 (sticky until reset), MEM/WB bubble, return to IDLE, mem_stall deasserted the following cycle.
  - A load that times out never writes back.
- Not defined: no counter; WAIT persists until dmem_ready; bus_err tied 0.

Test Plan:
- Zero-wait load: m_MEM=3'b010, wb_MEM=2'b11, res=0x40, write_register_ex=8, dmem_ready=1, dmem_rdata=0xDEADBEEF -> no stall. Next cycle: rd_WB=8, wb_WB=2'b11, write_data_reg=0xDEADBEEF.
- 3-wait store: m_MEM=3'b001, res=0x100, write_data_ex=0x1234, ready after 3 cycles -> mem_stall high 3 cycles; dmem_addr=0x100, dmem_we=1, dmem_wdata=0x1234 held stable throughout; wb_WB=0 during stall.
- ALU op bypass: m_MEM=0, wb_MEM=2'b10, res=0x55 -> dmem_req=0; next cycle res_wb=0x55, write_data_reg=0x55.
- Branch: m_MEM=3'b100, zero=1 -> pc_src=1. With zero=0 -> pc_src=0.
- Misaligned load: res=0x42 -> align_err pulses 1 cycle, dmem_req=0, wb_WB=0 next cycle.
- MEM_TIMEOUT_EN with TIMEOUT=4: load, dmem_ready never asserted -> abort after 4 WAIT cycles; bus_err=1 and stays 1; wb_WB=0. rst_n low clears bus_err.
